// File: rtl/eeprom_boot_loader.sv
// Copies a checksummed config image from EEPROM into the config register file after reset,
// then shares the EEPROM byte reader with a host through a single-request req/ack handshake.
module eeprom_boot_loader #(
  parameter logic [10:0] BASE_ADDR = 11'h000,
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter int          MAX_LEN   = 64,
  parameter int          TIMEOUT   = 1 << 20
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] ee_addr,
  output logic        ee_read,
  input  logic [7:0]  ee_data,
  input  logic        ee_data_ready,
  output logic        cfg_we,
  output logic [7:0]  cfg_waddr,
  output logic [7:0]  cfg_wdata,
  output logic        boot_done,
  output logic        boot_ok,
  output logic [1:0]  boot_err,
  input  logic        host_req,
  input  logic [10:0] host_addr,
  output logic        host_ack,
  output logic [7:0]  host_data
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    START, ISSUE, WAIT, CHECK, PASS, FAIL, HOST_IDLE, HOST_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    idx_q, idx_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    byte_q, byte_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [10:0]   ee_addr_q, ee_addr_d;
  logic          ee_read_q, ee_read_d;
  logic          cfg_we_q, cfg_we_d;
  logic [7:0]    cfg_waddr_q, cfg_waddr_d;
  logic [7:0]    cfg_wdata_q, cfg_wdata_d;
  logic          boot_done_q, boot_done_d;
  logic          boot_ok_q, boot_ok_d;
  logic [1:0]    boot_err_q, boot_err_d;
  logic          host_ack_q, host_ack_d;
  logic [7:0]    host_data_q, host_data_d;

  logic          in_payload;
  logic [7:0]    sum_next;

  // len_q is only meaningful once idx has passed the length byte, which is the only time this is used
  assign in_payload = (idx_q >= 9'd2) && (idx_q < ({1'b0, len_q} + 9'd2));
  assign sum_next   = sum_q + byte_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    sum_d       = sum_q;
    byte_d      = byte_q;
    tmo_d       = tmo_q;
    ee_addr_d   = ee_addr_q;
    ee_read_d   = 1'b0;
    cfg_we_d    = 1'b0;
    cfg_waddr_d = cfg_waddr_q;
    cfg_wdata_d = cfg_wdata_q;
    boot_done_d = boot_done_q;
    boot_ok_d   = boot_ok_q;
    boot_err_d  = boot_err_q;
    host_ack_d  = 1'b0;
    host_data_d = host_data_q;

    case (state_q)
      START: begin
        idx_d   = 9'd0;
        sum_d   = 8'd0;
        state_d = ISSUE;
      end
      ISSUE: begin
        ee_addr_d = BASE_ADDR + {2'b00, idx_q};
        ee_read_d = 1'b1;
        tmo_d     = TW'(TIMEOUT);
        state_d   = WAIT;
      end
      WAIT: begin
        if (ee_data_ready) begin
          byte_d  = ee_data;
          state_d = CHECK;
          // Payload write is issued straight from the reader pulse so it lands one cycle later
          if (in_payload) begin
            cfg_we_d    = 1'b1;
            cfg_waddr_d = 8'(idx_q - 9'd2);
            cfg_wdata_d = ee_data;
          end
        end else if (tmo_q == '0) begin
          boot_done_d = 1'b1;
          boot_ok_d   = 1'b0;
          boot_err_d  = 2'd3;
          state_d     = FAIL;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      CHECK: begin
        if (idx_q == 9'd0) begin
          if (byte_q != MAGIC) begin
            boot_done_d = 1'b1;
            boot_ok_d   = 1'b0;
            boot_err_d  = 2'd1;
            state_d     = FAIL;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = ISSUE;
          end
        end else if (idx_q == 9'd1) begin
          len_d = byte_q;
          if ((byte_q == 8'd0) || (byte_q > 8'(MAX_LEN))) begin
            boot_done_d = 1'b1;
            boot_ok_d   = 1'b0;
            boot_err_d  = 2'd2;
            state_d     = FAIL;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = ISSUE;
          end
        end else if (in_payload) begin
          sum_d   = sum_next;
          idx_d   = idx_q + 9'd1;
          state_d = ISSUE;
        end else begin
          boot_done_d = 1'b1;
          if (sum_next == 8'd0) begin
            boot_ok_d  = 1'b1;
            boot_err_d = 2'd0;
            state_d    = PASS;
          end else begin
            boot_ok_d  = 1'b0;
            boot_err_d = 2'd3;
            state_d    = FAIL;
          end
        end
      end
      PASS: begin
        boot_done_d = 1'b1;
        boot_ok_d   = 1'b1;
        state_d     = HOST_IDLE;
      end
      FAIL: begin
        boot_done_d = 1'b1;
        boot_ok_d   = 1'b0;
        state_d     = HOST_IDLE;
      end
      HOST_IDLE: begin
        // The host still holds req during its ack cycle; accepting it then would issue a duplicate read
        if (host_req && !host_ack_q) begin
          ee_addr_d = host_addr;
          ee_read_d = 1'b1;
          tmo_d     = TW'(TIMEOUT);
          state_d   = HOST_WAIT;
        end
      end
      HOST_WAIT: begin
        if (ee_data_ready) begin
          host_data_d = ee_data;
          host_ack_d  = 1'b1;
          state_d     = HOST_IDLE;
        end else if (tmo_q == '0) begin
          host_data_d = 8'hFF;
          host_ack_d  = 1'b1;
          state_d     = HOST_IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= START;
      idx_q       <= 9'd0;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      byte_q      <= 8'd0;
      tmo_q       <= '0;
      ee_addr_q   <= BASE_ADDR;
      ee_read_q   <= 1'b0;
      cfg_we_q    <= 1'b0;
      cfg_waddr_q <= 8'd0;
      cfg_wdata_q <= 8'd0;
      boot_done_q <= 1'b0;
      boot_ok_q   <= 1'b0;
      boot_err_q  <= 2'd0;
      host_ack_q  <= 1'b0;
      host_data_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      byte_q      <= byte_d;
      tmo_q       <= tmo_d;
      ee_addr_q   <= ee_addr_d;
      ee_read_q   <= ee_read_d;
      cfg_we_q    <= cfg_we_d;
      cfg_waddr_q <= cfg_waddr_d;
      cfg_wdata_q <= cfg_wdata_d;
      boot_done_q <= boot_done_d;
      boot_ok_q   <= boot_ok_d;
      boot_err_q  <= boot_err_d;
      host_ack_q  <= host_ack_d;
      host_data_q <= host_data_d;
    end
  end

  assign ee_addr   = ee_addr_q;
  assign ee_read   = ee_read_q;
  assign cfg_we    = cfg_we_q;
  assign cfg_waddr = cfg_waddr_q;
  assign cfg_wdata = cfg_wdata_q;
  assign boot_done = boot_done_q;
  assign boot_ok   = boot_ok_q;
  assign boot_err  = boot_err_q;
  assign host_ack  = host_ack_q;
  assign host_data = host_data_q;

endmodule
